// File: rtl/sym_err_counter_pkg.sv
// Shared types and defaults for the symbol error counter.
package sym_err_counter_pkg;

    // Acquisition state: searching for the end-to-end delay, or tracking errors at a fixed tap.
    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int unsigned DEF_MAX_DELAY   = 8;
    localparam int unsigned DEF_SYM_W       = 2;
    localparam int unsigned DEF_CNT_W       = 22;
    localparam int unsigned DEF_ACQ_LEN     = 64;
    localparam int unsigned DEF_ACQ_ERR_THR = 4;
    localparam int unsigned DEF_LOSS_THR    = 16;

    // Tap-select width; never zero so that a single-tap line still has a port.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sym_err_counter_delay_line.sv
// Reference-symbol shift register with a selectable output tap.
module sym_delay_line
    import sym_err_counter_pkg::*;
#(
    parameter int unsigned SYM_W     = DEF_SYM_W,
    parameter int unsigned MAX_DELAY = DEF_MAX_DELAY,
    localparam int unsigned SEL_W    = sel_width(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [SYM_W-1:0] din,
    input  logic [SEL_W-1:0] sel,
    output logic [SYM_W-1:0] tap
);

    // dl[k] holds the reference symbol from k+1 enables ago.
    logic [SYM_W-1:0] dl [MAX_DELAY];

    // Shift on each symbol enable; synchronous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned k = 0; k < MAX_DELAY; k++) begin
                dl[k] <= '0;
            end
        end else if (clk_en) begin
            dl[0] <= din;
            for (int unsigned k = 1; k < MAX_DELAY; k++) begin
                dl[k] <= dl[k-1];
            end
        end
    end

    // Tap mux; an out-of-range select reads as zero.
    always_comb begin
        tap = '0;
        for (int unsigned k = 0; k < MAX_DELAY; k++) begin
            if (sel == SEL_W'(k)) begin
                tap = dl[k];
            end
        end
    end

endmodule

// File: rtl/sym_err_counter.sv
// Self-aligning symbol error counter: searches the delay tap that lines the transmitted
// reference up with the slicer output, then counts errors per LFSR period.
module sym_err_counter
    import sym_err_counter_pkg::*;
#(
    parameter int unsigned MAX_DELAY   = DEF_MAX_DELAY,
    parameter int unsigned SYM_W       = DEF_SYM_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned ACQ_LEN     = DEF_ACQ_LEN,
    parameter int unsigned ACQ_ERR_THR = DEF_ACQ_ERR_THR,
    parameter int unsigned LOSS_THR    = DEF_LOSS_THR,
    localparam int unsigned SEL_W      = sel_width(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             hold,
    input  logic [SYM_W-1:0] sym_ref,
    input  logic [SYM_W-1:0] sym_rx,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sym_count,
    output logic             locked,
    output logic [SEL_W-1:0] delay_sel,
    output logic             sym_error
);

    localparam int unsigned WC_W = (ACQ_LEN > 1) ? $clog2(ACQ_LEN) : 1;
    localparam int unsigned WE_W = $clog2(ACQ_LEN + 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] delay_sel_q, delay_sel_d, delay_next;
    logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
    logic [WE_W-1:0]  win_err_q, win_err_d, win_err_inc;
    logic [CNT_W-1:0] acc_err_q, acc_err_d, acc_err_inc;
    logic [CNT_W-1:0] acc_sym_q, acc_sym_d, acc_sym_inc;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] sym_count_q, sym_count_d;
    logic             sym_error_q, sym_error_d;
    logic [SYM_W-1:0] tap;
    logic             mis, win_end;

    sym_delay_line #(
        .SYM_W     (SYM_W),
        .MAX_DELAY (MAX_DELAY)
    ) u_delay_line (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .din    (sym_ref),
        .sel    (delay_sel_q),
        .tap    (tap)
    );

    // Per-symbol compare and saturating increments, shared by both states.
    always_comb begin
        mis         = (sym_rx != tap);
        win_end     = (win_cnt_q == WC_W'(ACQ_LEN - 1));
        win_err_inc = (mis && (win_err_q != '1)) ? win_err_q + WE_W'(1) : win_err_q;
        acc_err_inc = (mis && (acc_err_q != '1)) ? acc_err_q + CNT_W'(1) : acc_err_q;
        acc_sym_inc = (acc_sym_q != '1) ? acc_sym_q + CNT_W'(1) : acc_sym_q;
        delay_next  = (delay_sel_q == SEL_W'(MAX_DELAY - 1)) ? '0 : delay_sel_q + SEL_W'(1);
    end

    // Next-state: window bookkeeping, search/lock decisions and period latching.
    always_comb begin
        state_d     = state_q;
        delay_sel_d = delay_sel_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        acc_err_d   = acc_err_q;
        acc_sym_d   = acc_sym_q;
        err_count_d = err_count_q;
        sym_count_d = sym_count_q;
        sym_error_d = sym_error_q;

        if (clk_en) begin
            win_cnt_d = win_end ? '0 : win_cnt_q + WC_W'(1);
            win_err_d = win_end ? '0 : win_err_inc;

            unique case (state_q)
                SEARCH: begin
                    sym_error_d = 1'b0;
                    if (win_end) begin
                        if (32'(win_err_inc) <= ACQ_ERR_THR) begin
                            state_d = LOCKED;
                        end else begin
                            delay_sel_d = delay_next;
                        end
                    end
                end
                LOCKED: begin
                    sym_error_d = mis;
                    acc_err_d   = acc_err_inc;
                    acc_sym_d   = acc_sym_inc;
                    // Current symbol belongs to the period being closed.
                    if (hold) begin
                        err_count_d = acc_err_inc;
                        sym_count_d = acc_sym_inc;
                        acc_err_d   = '0;
                        acc_sym_d   = '0;
                    end
                    if (win_end && (32'(win_err_inc) >= LOSS_THR)) begin
                        state_d     = SEARCH;
                        delay_sel_d = delay_next;
                        acc_err_d   = '0;
                        acc_sym_d   = '0;
                        sym_error_d = 1'b0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SEARCH;
            delay_sel_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            acc_err_q   <= '0;
            acc_sym_q   <= '0;
            err_count_q <= '0;
            sym_count_q <= '0;
            sym_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            delay_sel_q <= delay_sel_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            acc_err_q   <= acc_err_d;
            acc_sym_q   <= acc_sym_d;
            err_count_q <= err_count_d;
            sym_count_q <= sym_count_d;
            sym_error_q <= sym_error_d;
        end
    end

    // Outputs are straight register reads.
    always_comb begin
        err_count = err_count_q;
        sym_count = sym_count_q;
        locked    = (state_q == LOCKED);
        delay_sel = delay_sel_q;
        sym_error = sym_error_q;
    end

endmodule

// File: tb/tb_sym_err_counter.sv
// Directed bench for sym_err_counter: acquisition, counting, loss of lock, gating,
// reset and counter saturation (second instance with narrow counters).
module tb_sym_err_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, reset_s, clk_en, hold;
    logic [1:0]  sym_ref, sym_rx;
    logic [21:0] err_count, sym_count;
    logic        locked, sym_error;
    logic [2:0]  delay_sel;
    logic [3:0]  s_err_count, s_sym_count;
    logic        s_locked, s_sym_error;
    logic [2:0]  s_delay_sel;

    int checks = 0;
    int errors = 0;

    // hist[k] is the reference symbol driven k enables ago (hist[0] = current).
    logic [1:0] hist [16];

    sym_err_counter dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .hold      (hold),
        .sym_ref   (sym_ref),
        .sym_rx    (sym_rx),
        .err_count (err_count),
        .sym_count (sym_count),
        .locked    (locked),
        .delay_sel (delay_sel),
        .sym_error (sym_error)
    );

    sym_err_counter #(
        .CNT_W    (4),
        .LOSS_THR (65)
    ) dut_sat (
        .clk       (clk),
        .reset     (reset_s),
        .clk_en    (clk_en),
        .hold      (hold),
        .sym_ref   (sym_ref),
        .sym_rx    (sym_rx),
        .err_count (s_err_count),
        .sym_count (s_sym_count),
        .locked    (s_locked),
        .delay_sel (s_delay_sel),
        .sym_error (s_sym_error)
    );

    // One enabled symbol: new random reference, rx = reference from dly enables ago.
    task automatic step(input int dly, input logic flip, input logic h);
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = 2'($urandom_range(0, 3));
        sym_ref = hist[0];
        sym_rx  = hist[dly] ^ {1'b0, flip};
        hold    = h;
        clk_en  = 1'b1;
        @(posedge clk);
        #1;
        hold = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (err_count !== 22'd0 || sym_count !== 22'd0) begin
            errors++;
            $display("FAIL reset_counts: got %0d/%0d, expected 0/0", err_count, sym_count);
        end
        checks++;
        if (locked !== 1'b0 || delay_sel !== 3'd0 || sym_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got locked=%b sel=%0d err=%b, expected 0/0/0",
                     locked, delay_sel, sym_error);
        end
        reset = 1'b1;
    endtask

    task automatic test_lock();
        logic se_seen;
        se_seen = 1'b0;
        for (int i = 1; i <= 192; i++) begin
            step(3, 1'b0, 1'b0);
            if (sym_error) se_seen = 1'b1;
            if (i == 64) begin
                checks++;
                if (delay_sel !== 3'd1) begin
                    errors++;
                    $display("FAIL lock_sel_w1: got %0d, expected 1", delay_sel);
                end
            end
            if (i == 128) begin
                checks++;
                if (delay_sel !== 3'd2) begin
                    errors++;
                    $display("FAIL lock_sel_w2: got %0d, expected 2", delay_sel);
                end
            end
            if (i == 191) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_early: got locked=%b, expected 0", locked);
                end
            end
        end
        checks++;
        if (locked !== 1'b1 || delay_sel !== 3'd2) begin
            errors++;
            $display("FAIL lock_acq: got locked=%b sel=%0d, expected 1/2", locked, delay_sel);
        end
        checks++;
        if (se_seen !== 1'b0) begin
            errors++;
            $display("FAIL lock_sym_error: got %b, expected 0", se_seen);
        end
    endtask

    task automatic test_error_count();
        logic flip;
        step(3, 1'b0, 1'b1);
        checks++;
        if (err_count !== 22'd0 || sym_count !== 22'd1) begin
            errors++;
            $display("FAIL count_first: got %0d/%0d, expected 0/1", err_count, sym_count);
        end
        for (int i = 0; i < 1000; i++) begin
            flip = (i == 100 || i == 250 || i == 400 || i == 700 || i == 999);
            step(3, flip, i == 999);
            if (i == 100) begin
                checks++;
                if (sym_error !== 1'b1) begin
                    errors++;
                    $display("FAIL count_sym_error: got %b, expected 1", sym_error);
                end
            end
            if (i == 101) begin
                checks++;
                if (sym_error !== 1'b0) begin
                    errors++;
                    $display("FAIL count_sym_ok: got %b, expected 0", sym_error);
                end
            end
        end
        checks++;
        if (err_count !== 22'd5 || sym_count !== 22'd1000) begin
            errors++;
            $display("FAIL count_period: got %0d/%0d, expected 5/1000", err_count, sym_count);
        end
        checks++;
        if (locked !== 1'b1 || delay_sel !== 3'd2) begin
            errors++;
            $display("FAIL count_lock: got locked=%b sel=%0d, expected 1/2", locked, delay_sel);
        end
    endtask

    task automatic test_loss_of_lock();
        int n;
        n = 0;
        while (locked && n < 200) begin
            step(5, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (locked !== 1'b0 || n > 128) begin
            errors++;
            $display("FAIL loss_drop: got locked=%b after %0d, expected 0 within 128", locked, n);
        end
        checks++;
        if (delay_sel !== 3'd3 || sym_error !== 1'b0) begin
            errors++;
            $display("FAIL loss_sel: got sel=%0d err=%b, expected 3/0", delay_sel, sym_error);
        end
        n = 0;
        while (!locked && n < 300) begin
            step(5, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (locked !== 1'b1 || delay_sel !== 3'd4) begin
            errors++;
            $display("FAIL relock: got locked=%b sel=%0d, expected 1/4", locked, delay_sel);
        end
    endtask

    task automatic test_gating();
        clk_en = 1'b0;
        hold   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            sym_rx  = ~sym_rx;
            sym_ref = 2'(i);
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
        checks++;
        if (err_count !== 22'd5 || sym_count !== 22'd1000) begin
            errors++;
            $display("FAIL gate_counts: got %0d/%0d, expected 5/1000", err_count, sym_count);
        end
        checks++;
        if (locked !== 1'b1 || delay_sel !== 3'd4 || sym_error !== 1'b0) begin
            errors++;
            $display("FAIL gate_flags: got locked=%b sel=%0d err=%b, expected 1/4/0",
                     locked, delay_sel, sym_error);
        end
        // Gating must not have disturbed the delay line or accumulators either.
        sym_ref = hist[0];
        step(5, 1'b0, 1'b1);
        checks++;
        if (err_count !== 22'd0 || sym_count !== 22'd1) begin
            errors++;
            $display("FAIL gate_after: got %0d/%0d, expected 0/1", err_count, sym_count);
        end
    endtask

    task automatic test_reset_mid_lock();
        reset = 1'b0;
        step(5, 1'b0, 1'b0);
        reset = 1'b1;
        checks++;
        if (err_count !== 22'd0 || sym_count !== 22'd0 || locked !== 1'b0 ||
            delay_sel !== 3'd0 || sym_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got %0d/%0d locked=%b sel=%0d err=%b, expected all 0",
                     err_count, sym_count, locked, delay_sel, sym_error);
        end
        test_lock();
    endtask

    task automatic test_saturation();
        reset_s = 1'b1;
        for (int i = 0; i < 64; i++) step(1, 1'b0, 1'b0);
        checks++;
        if (s_locked !== 1'b1 || s_delay_sel !== 3'd0) begin
            errors++;
            $display("FAIL sat_lock: got locked=%b sel=%0d, expected 1/0", s_locked, s_delay_sel);
        end
        step(1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1, 1'b1, i == 19);
        checks++;
        if (s_err_count !== 4'd15 || s_sym_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_counts: got %0d/%0d, expected 15/15", s_err_count, s_sym_count);
        end
        checks++;
        if (s_locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_keep_lock: got %b, expected 1", s_locked);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        reset_s = 1'b0;
        clk_en  = 1'b0;
        hold    = 1'b0;
        sym_ref = 2'd0;
        sym_rx  = 2'd0;
        for (int k = 0; k < 16; k++) hist[k] = 2'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_lock();
        test_error_count();
        test_loss_of_lock();
        test_gating();
        test_reset_mid_lock();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
